uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares the single `uart_tx` transmitter among `NumReq` byte-stream requesters inside `uart_ctrl`. Each requester presents bytes on a valid/ready handshake, with a `last` flag marking the end of a packet. The scheduler grants one requester at a time and holds the grant for a whole packet, so bytes of different packets never interleave on the line. It issues one `tx_start_o` pulse per byte and waits for the transmitter's `tx_done_i` before taking the next byte. A watchdog releases the grant if the granted requester stalls in mid-packet.

## Interface
- `NumReq`, default 4: number of requesters, 2..8.
- `DataWidth`, default 8: byte width.
- `StallTimeout`, default 255: idle cycles allowed in mid-packet before the grant is revoked, 1..65535.

- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_valid_i`  in  NumReq  per-requester byte valid.
- `req_data_i`  in  NumReq×DataWidth  per-requester byte.
- `req_last_i`  in  NumReq  byte is the last of its packet.
- `req_ready_o`  out  NumReq  byte accepted this cycle (one-hot or zero).
- `grant_o`  out  NumReq  one-hot current owner; zero when idle.
- `tx_start_o`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_data_o`  out  DataWidth  byte to transmit; stable from `tx_start_o` until `tx_done_i`.
- `tx_busy_i`  in  1  transmitter busy.
- `tx_done_i`  in  1  one-cycle pulse when the stop bit completes.
- `stall_abort_o`  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- **Reset values.** All outputs are 0. State is IDLE. Round-robin pointer `ptr` is 0. Stall counter is 0. Last flag is 0.
- **IDLE**
  - If any `req_valid_i` is set, pick the first valid index scanning upward from `ptr` with wrap-around.
  - Register the winner into `grant_o` and go to ISSUE.
  - No handshake happens in IDLE.
- **ISSUE**
  - Handshake rule: `req_ready_o[g] = req_valid_i[g] & ~tx_busy_i`. All other ready bits are 0.
  - On a handshake:
    - latch `req_data_i[g]` into `tx_data_o`;
    - latch `req_last_i[g]`;
    - pulse `tx_start_o` in the next cycle;
    - go to WAIT;
    - clear the stall counter.
  - While there is no handshake, the stall counter increments, saturating.
  - When the counter reaches `StallTimeout`:
    - pulse `stall_abort_o`;
    - clear `grant_o`;
    - set `ptr = g+1 mod NumReq`;
    - go to IDLE.
- **WAIT**
  - Hold `grant_o` and `tx_data_o`.
  - On `tx_done_i`:
    - if the latched last flag is 1: clear `grant_o`, set `ptr = g+1 mod NumReq`, go to IDLE;
    - otherwise go to ISSUE, keeping the lock.
- **`tx_done_i` outside WAIT** is ignored.
- **`tx_busy_i` high in ISSUE** blocks the handshake. It does not increment the stall counter.
- **Only the granted requester** is served while locked. Other requesters' valids are ignored until the packet ends or is aborted.
- **Single-byte packet** (`last` = 1 on the first byte): the grant is released after one `tx_done_i`.
- **Reset mid-packet** drops the packet immediately. The next `tx_start_o` requires a fresh arbitration.

## Timing
- Cycle 0: valid asserted in IDLE.
- Cycle 1: `grant_o` set and state is ISSUE. The handshake happens in cycle 1 if `tx_busy_i` = 0.
- Cycle 2: `tx_start_o` pulse, `tx_data_o` valid.
- Best-case valid-to-start latency is 2 cycles.
- The byte after a non-last `tx_done_i` at cycle n: ISSUE at n+1, handshake at n+1, `tx_start_o` at n+2.
- After a last-byte `tx_done_i` at cycle n: IDLE at n+1, the next grant at n+2.
- `tx_start_o` is never asserted for two consecutive cycles.
- At most one `tx_start_o` is issued per `tx_done_i`.
- The stall abort fires exactly `StallTimeout` cycles after entering ISSUE, counting only cycles with `tx_busy_i` = 0 and no handshake.

## Structure
- `uart_pkg` holds:
  - the state typedef `uart_sched_state_e` with values IDLE, ISSUE, WAIT;
  - default constants `UartNumReq` = 4 and `UartDataWidth` = 8.
- Sub-module `rr_arbiter`: combinational. Inputs are the request vector and `ptr`. Outputs are the one-hot grant and the winner index.
- The FSM, latches and stall counter live in `uart_tx_sched`.

## Test plan
- **Single requester.** Requester 1 sends 0xA5 with last = 1 and `tx_busy_i` = 0. Expect `grant_o` = 0b0010 at cycle 1, `tx_start_o` with `tx_data_o` = 0xA5 at cycle 2, and `grant_o` = 0 the cycle after `tx_done_i`.
- **Round-robin.** Requesters 0, 2 and 3 each hold a single-byte packet (0x10, 0x20, 0x30) from reset. Expect grants and tx bytes in the order 0, 2, 3. Then re-assert 0 and 3; expect order 0, 3 (after 3 the pointer wraps to 0).
- **Packet lock.** Requester 0 sends 3 bytes 0x01 0x02 0x03 (last on 0x03) while requester 1 holds a valid. Expect tx order 0x01 0x02 0x03, then requester 1's byte, with no interleaving.
- **Busy backpressure.** `tx_busy_i` = 1 for 10 cycles in ISSUE. Expect `req_ready_o` = 0 throughout and no stall abort. The handshake occurs in the cycle `tx_busy_i` falls.
- **Stall abort.** `StallTimeout` = 4. Requester 2 sends one non-last byte, then drops valid. Expect `stall_abort_o` 4 ISSUE cycles after `tx_done_i`, `grant_o` cleared, and the next grant going to requester 3 if it is valid.
- **Reset mid-packet.** Assert `rst_i` during WAIT. Expect all outputs 0 immediately. After release with requester 0 valid, expect a grant 1 cycle later.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the uart_ctrl transmit path.
// Imported by the transmit scheduler and its arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } uart_sched_state_e;

    localparam int UartNumReq    = 4;
    localparam int UartDataWidth = 8;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i,
// wrapping past the top index back to 0.
module rr_arbiter #(
    parameter int NumReq = 4,
    parameter int PtrW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [PtrW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [PtrW-1:0]   idx_o
);

    logic          found;
    logic [PtrW:0] sum;
    logic [PtrW-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        sum   = '0;
        j     = '0;
        for (int i = 0; i < NumReq; i++) begin
            sum = {1'b0, ptr_i} + (PtrW+1)'(i);
            if (sum >= (PtrW+1)'(NumReq)) begin
                sum = sum - (PtrW+1)'(NumReq);
            end
            j = sum[PtrW-1:0];
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx among NumReq byte streams, locking the grant for a
// whole packet; a stall watchdog frees a grant whose owner goes quiet.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NumReq       = UartNumReq,
    parameter int DataWidth    = UartDataWidth,
    parameter int StallTimeout = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumReq-1:0]                req_valid_i,
    input  logic [NumReq-1:0][DataWidth-1:0] req_data_i,
    input  logic [NumReq-1:0]                req_last_i,
    output logic [NumReq-1:0]                req_ready_o,
    output logic [NumReq-1:0]                grant_o,
    output logic                             tx_start_o,
    output logic [DataWidth-1:0]             tx_data_o,
    input  logic                             tx_busy_i,
    input  logic                             tx_done_i,
    output logic                             stall_abort_o
);

    localparam int          PtrW      = $clog2(NumReq);
    localparam logic [15:0] StallLast = 16'(StallTimeout - 1);

    uart_sched_state_e state;

    logic [PtrW-1:0]   ptr;
    logic [PtrW-1:0]   gidx;
    logic [PtrW-1:0]   gidx_next;
    logic [PtrW-1:0]   arb_idx;
    logic [NumReq-1:0] arb_gnt;
    logic [15:0]       stall_cnt;
    logic              last_q;
    logic              hs;

    rr_arbiter #(
        .NumReq (NumReq),
        .PtrW   (PtrW)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (ptr),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign req_ready_o = (state == ISSUE && !tx_busy_i)
                       ? (grant_o & req_valid_i) : '0;
    assign hs          = |req_ready_o;
    assign gidx_next   = (gidx == PtrW'(NumReq - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            ptr           <= '0;
            gidx          <= '0;
            grant_o       <= '0;
            tx_start_o    <= 1'b0;
            tx_data_o     <= '0;
            stall_abort_o <= 1'b0;
            stall_cnt     <= '0;
            last_q        <= 1'b0;
        end else begin
            tx_start_o    <= 1'b0;
            stall_abort_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req_valid_i) begin
                        grant_o <= arb_gnt;
                        gidx    <= arb_idx;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        tx_data_o  <= req_data_i[gidx];
                        last_q     <= req_last_i[gidx];
                        tx_start_o <= 1'b1;
                        stall_cnt  <= '0;
                        state      <= WAIT;
                    end else if (!tx_busy_i) begin
                        // Busy cycles are the transmitter's fault, not the owner's.
                        if (stall_cnt >= StallLast) begin
                            stall_abort_o <= 1'b1;
                            grant_o       <= '0;
                            ptr           <= gidx_next;
                            stall_cnt     <= '0;
                            state         <= IDLE;
                        end else if (stall_cnt != '1) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (tx_done_i) begin
                        if (last_q) begin
                            grant_o <= '0;
                            ptr     <= gidx_next;
                            state   <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a 4-cycle stall watchdog.
// The bench plays the part of uart_tx by pulsing tx_done_i by hand.
module tb_uart_tx_sched;

    logic            clk_i;
    logic            rst_i;
    logic [3:0]      req_valid_i;
    logic [3:0][7:0] req_data_i;
    logic [3:0]      req_last_i;
    logic [3:0]      req_ready_o;
    logic [3:0]      grant_o;
    logic            tx_start_o;
    logic [7:0]      tx_data_o;
    logic            tx_busy_i;
    logic            tx_done_i;
    logic            stall_abort_o;

    int n_chk;
    int n_fail;
    int bad;

    uart_tx_sched #(
        .NumReq       (4),
        .DataWidth    (8),
        .StallTimeout (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_data_i    (req_data_i),
        .req_last_i    (req_last_i),
        .req_ready_o   (req_ready_o),
        .grant_o       (grant_o),
        .tx_start_o    (tx_start_o),
        .tx_data_o     (tx_data_o),
        .tx_busy_i     (tx_busy_i),
        .tx_done_i     (tx_done_i),
        .stall_abort_o (stall_abort_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
    endtask

    // Waits (bounded) for tx_start_o; checks latency, owner and byte.
    task automatic expect_start(input string tag, input logic [1:0] idx,
                                input logic [7:0] d, input int lat);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (tx_start_o !== 1'b1 && n < 20);
        check({tag, "_lat"}, n, lat);
        check({tag, "_gnt"}, grant_o, 4'b0001 << idx);
        check({tag, "_dat"}, tx_data_o, d);
    endtask

    // Called in the tx_start cycle: present the next byte, then pulse done.
    task automatic finish_byte(input logic [1:0] idx, input logic nv,
                               input logic [7:0] nd, input logic nl);
        req_valid_i[idx] = nv;
        req_data_i[idx]  = nd;
        req_last_i[idx]  = nl;
        cyc();
        check("no_b2b", tx_start_o, 1'b0);
        tx_done_i = 1'b1;
        cyc();
        tx_done_i = 1'b0;
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        tx_busy_i   = 1'b0;
        tx_done_i   = 1'b0;
        repeat (2) cyc();
        check("rst_gnt", grant_o, 4'b0000);
        check("rst_start", tx_start_o, 1'b0);
        check("rst_data", tx_data_o, 8'h00);
        check("rst_ready", req_ready_o, 4'b0000);
        check("rst_abort", stall_abort_o, 1'b0);

        // Single requester, single-byte packet
        rst_i          = 1'b0;
        req_valid_i[1] = 1'b1;
        req_data_i[1]  = 8'hA5;
        req_last_i[1]  = 1'b1;
        #1;
        check("t1_c0_gnt", grant_o, 4'b0000);
        check("t1_c0_rdy", req_ready_o, 4'b0000);
        cyc();
        check("t1_c1_gnt", grant_o, 4'b0010);
        check("t1_c1_rdy", req_ready_o, 4'b0010);
        expect_start("t1", 2'd1, 8'hA5, 1);
        finish_byte(2'd1, 1'b0, 8'h00, 1'b0);
        check("t1_rel", grant_o, 4'b0000);

        // Round-robin from reset: 0, 2, 3 then 0, 3
        do_reset();
        req_valid_i = 4'b1101;
        req_data_i  = {8'h30, 8'h20, 8'h00, 8'h10};
        req_last_i  = 4'b1101;
        expect_start("rr0", 2'd0, 8'h10, 2);
        finish_byte(2'd0, 1'b0, 8'h00, 1'b0);
        check("rr_idle", grant_o, 4'b0000);
        cyc();
        check("rr_next", grant_o, 4'b0100);
        expect_start("rr2", 2'd2, 8'h20, 1);
        finish_byte(2'd2, 1'b0, 8'h00, 1'b0);
        expect_start("rr3", 2'd3, 8'h30, 2);
        finish_byte(2'd3, 1'b0, 8'h00, 1'b0);
        req_valid_i = 4'b1001;
        req_data_i  = {8'h33, 8'h00, 8'h00, 8'h11};
        req_last_i  = 4'b1001;
        expect_start("rr0b", 2'd0, 8'h11, 2);
        finish_byte(2'd0, 1'b0, 8'h00, 1'b0);
        expect_start("rr3b", 2'd3, 8'h33, 2);
        finish_byte(2'd3, 1'b0, 8'h00, 1'b0);

        // Packet lock: 0 sends 3 bytes while 1 waits
        req_valid_i[0] = 1'b1; req_data_i[0] = 8'h01; req_last_i[0] = 1'b0;
        req_valid_i[1] = 1'b1; req_data_i[1] = 8'h55; req_last_i[1] = 1'b1;
        expect_start("lk1", 2'd0, 8'h01, 2);
        finish_byte(2'd0, 1'b1, 8'h02, 1'b0);
        expect_start("lk2", 2'd0, 8'h02, 1);
        finish_byte(2'd0, 1'b1, 8'h03, 1'b1);
        expect_start("lk3", 2'd0, 8'h03, 1);
        finish_byte(2'd0, 1'b0, 8'h00, 1'b0);
        expect_start("lk_r1", 2'd1, 8'h55, 2);
        finish_byte(2'd1, 1'b0, 8'h00, 1'b0);

        // Busy backpressure for 10 ISSUE cycles (ptr now 2)
        req_valid_i[2] = 1'b1; req_data_i[2] = 8'h77; req_last_i[2] = 1'b1;
        tx_busy_i = 1'b1;
        cyc();
        check("bp_gnt", grant_o, 4'b0100);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (req_ready_o !== 4'b0000 || stall_abort_o !== 1'b0
                || tx_start_o !== 1'b0) bad++;
            cyc();
        end
        check("bp_hold", bad, 0);
        tx_busy_i = 1'b0;
        #1;
        check("bp_hs", req_ready_o, 4'b0100);
        expect_start("bp", 2'd2, 8'h77, 1);
        finish_byte(2'd2, 1'b0, 8'h00, 1'b0);

        // Stall abort: 2 sends one non-last byte then goes quiet (ptr now 3)
        req_valid_i[2] = 1'b1; req_data_i[2] = 8'h99; req_last_i[2] = 1'b0;
        expect_start("st", 2'd2, 8'h99, 2);
        req_valid_i[2] = 1'b0;
        req_valid_i[3] = 1'b1; req_data_i[3] = 8'hC3; req_last_i[3] = 1'b1;
        cyc();
        tx_done_i = 1'b1;
        cyc();
        tx_done_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (grant_o !== 4'b0100 || stall_abort_o !== 1'b0
                || req_ready_o !== 4'b0000) bad++;
            cyc();
        end
        check("st_wait", bad, 0);
        check("st_abort", stall_abort_o, 1'b1);
        check("st_clr", grant_o, 4'b0000);
        cyc();
        check("st_pulse", stall_abort_o, 1'b0);
        check("st_next", grant_o, 4'b1000);
        expect_start("st3", 2'd3, 8'hC3, 1);
        finish_byte(2'd3, 1'b0, 8'h00, 1'b0);

        // Reset during WAIT
        req_valid_i[1] = 1'b1; req_data_i[1] = 8'h42; req_last_i[1] = 1'b0;
        expect_start("rm", 2'd1, 8'h42, 2);
        cyc();
        rst_i = 1'b1;
        req_valid_i[1] = 1'b0;
        req_valid_i[0] = 1'b1; req_data_i[0] = 8'h0F; req_last_i[0] = 1'b1;
        #1;
        check("rm_gnt", grant_o, 4'b0000);
        check("rm_data", tx_data_o, 8'h00);
        check("rm_ready", req_ready_o, 4'b0000);
        cyc();
        rst_i = 1'b0;
        #1;
        check("rm_idle", grant_o, 4'b0000);
        cyc();
        check("rm_gnt0", grant_o, 4'b0001);
        expect_start("rm0", 2'd0, 8'h0F, 1);
        finish_byte(2'd0, 1'b0, 8'h00, 1'b0);
        check("rm_rel", grant_o, 4'b0000);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
